// File: rtl/flag_reduce_pkg.sv
// Shared types and sizing helpers for the sequential OR-reduce flag unit.
// Used by flag_reduce_seq and chunk_lzd.
package flag_reduce_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nch(input int w, input int c);
        return w / c;
    endfunction

    function automatic int idx_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/flag_reduce_seq_chunk_lzd.sv
// Combinational leading-zero count of one CHUNK-bit slice.
// Only instantiated when FLAG_MSB_IDX_EN is defined.
module chunk_lzd
    import flag_reduce_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK,
    localparam int LZW = idx_w(CHUNK)
) (
    input  logic [CHUNK-1:0] slice_i,
    output logic [LZW-1:0]   lz_o,
    output logic             nz_o
);

    // Ascending scan so the highest set bit is the last to assign lz_o.
    always_comb begin
        lz_o = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (slice_i[i]) begin
                lz_o = LZW'(CHUNK - 1 - i);
            end
        end
    end

    assign nz_o = |slice_i;

endmodule

// File: rtl/flag_reduce_seq.sv
// Multi-cycle MSB-first OR-reduce with any_set/zero flags.
// Define FLAG_MSB_IDX_EN to add the msb_idx output and its detector.
module flag_reduce_seq
    import flag_reduce_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK,
    localparam int IDXW = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             any_set,
    output logic             zero
`ifdef FLAG_MSB_IDX_EN
    ,
    output logic [IDXW-1:0]  msb_idx
`endif
);

    localparam int NCH = nch(WIDTH, CHUNK);
    localparam logic [IDXW-1:0] LAST = IDXW'(NCH - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sh_q;
    logic [IDXW-1:0]   cnt_q;
    logic              acc_q;
    logic              any_q, zero_q;
    logic [CHUNK-1:0]  slice;
    logic              slice_nz;
    logic              scan, last, load, acc_d;

    assign slice = sh_q[WIDTH-1 -: CHUNK];
    assign scan  = (state_q == SCAN);
    assign last  = scan && (cnt_q == LAST);
    assign load  = start && (state_q != SCAN);
    assign acc_d = acc_q | slice_nz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (last) state_d = DONE;
            DONE:    state_d = start ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SCAN);
        done = (state_q == DONE);
    end

    // Flags are latched from the final slice so they hold across the next scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            acc_q  <= 1'b0;
            any_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (load) begin
            sh_q  <= data_in;
            cnt_q <= '0;
            acc_q <= 1'b0;
        end else if (scan) begin
            sh_q  <= sh_q << CHUNK;
            cnt_q <= cnt_q + IDXW'(1);
            acc_q <= acc_d;
            if (last) begin
                any_q  <= acc_d;
                zero_q <= ~acc_d;
            end
        end
    end

    assign any_set = any_q;
    assign zero    = zero_q;

`ifdef FLAG_MSB_IDX_EN
    localparam int LZW = idx_w(CHUNK);

    logic [LZW-1:0]  lz;
    logic            found_q;
    logic [IDXW-1:0] idx_q, idx_d, msb_q;

    chunk_lzd #(
        .CHUNK (CHUNK)
    ) u_lzd (
        .slice_i (slice),
        .lz_o    (lz),
        .nz_o    (slice_nz)
    );

    always_comb begin
        idx_d = idx_q;
        if (!found_q && slice_nz) begin
            idx_d = IDXW'(WIDTH - 1 - int'(cnt_q) * CHUNK - int'(lz));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            found_q <= 1'b0;
            idx_q   <= '0;
            msb_q   <= '0;
        end else if (load) begin
            found_q <= 1'b0;
            idx_q   <= '0;
        end else if (scan) begin
            found_q <= found_q | slice_nz;
            idx_q   <= idx_d;
            if (last) begin
                msb_q <= idx_d;
            end
        end
    end

    assign msb_idx = msb_q;
`else
    assign slice_nz = |slice;
`endif

endmodule

// File: tb/tb_flag_reduce_seq.sv
// Directed self-checking bench for flag_reduce_seq (32/8 and 16/4).
// msb_idx checks are compiled in only with FLAG_MSB_IDX_EN.
module tb_flag_reduce_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] din = '0;
    logic        busy, done, any_set, zero;
    logic        start16 = 1'b0;
    logic [15:0] din16 = '0;
    logic        busy16, done16, any16, zero16;
`ifdef FLAG_MSB_IDX_EN
    logic [4:0]  msb_idx, r_msb;
    logic [3:0]  msb16;
`endif

    int cmp = 0;
    int err = 0;
    int lat, ndone, nbusy;
    logic r_any, r_zero;

    always #5 clk = ~clk;

    flag_reduce_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (din),
        .busy    (busy),
        .done    (done),
        .any_set (any_set),
        .zero    (zero)
`ifdef FLAG_MSB_IDX_EN
        ,
        .msb_idx (msb_idx)
`endif
    );

    flag_reduce_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk     (clk),
        .rst     (rst),
        .start   (start16),
        .data_in (din16),
        .busy    (busy16),
        .done    (done16),
        .any_set (any16),
        .zero    (zero16)
`ifdef FLAG_MSB_IDX_EN
        ,
        .msb_idx (msb16)
`endif
    );

    // One operation on the 32-bit unit; records first done and its outputs.
    task automatic op32(input logic [31:0] d, input bit hold);
        lat = 0;
        ndone = 0;
        nbusy = 0;
        @(negedge clk);
        start = 1'b1;
        din = d;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = i;
                    r_any = any_set;
                    r_zero = zero;
`ifdef FLAG_MSB_IDX_EN
                    r_msb = msb_idx;
`endif
                end
                start = 1'b0;
            end else if (!hold) begin
                start = 1'b0;
            end else begin
                din = ~din;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        cmp++;
        if ({busy, done, any_set, zero} !== 4'b0000) begin
            err++;
            $display("FAIL reset_flags: got %b want 0000",
                     {busy, done, any_set, zero});
        end
`ifdef FLAG_MSB_IDX_EN
        cmp++;
        if (msb_idx !== 5'd0) begin
            err++;
            $display("FAIL reset_msb: got %0d want 0", msb_idx);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_vec(input string nm, input logic [31:0] d,
                            input logic e_any, input int e_msb);
        op32(d, 1'b0);
        cmp++;
        if (lat !== 5 || ndone !== 1 || nbusy !== 4) begin
            err++;
            $display("FAIL %s_timing: lat=%0d dones=%0d busy=%0d want 5/1/4",
                     nm, lat, ndone, nbusy);
        end
        cmp++;
        if (r_any !== e_any || r_zero !== ~e_any) begin
            err++;
            $display("FAIL %s_flags: any=%b zero=%b want any=%b zero=%b",
                     nm, r_any, r_zero, e_any, ~e_any);
        end
`ifdef FLAG_MSB_IDX_EN
        cmp++;
        if (int'(r_msb) !== e_msb) begin
            err++;
            $display("FAIL %s_msb: got %0d want %0d", nm, r_msb, e_msb);
        end
`else
        if (e_msb < 0) $display("note: negative msb expectation");
`endif
    endtask

    task automatic test_hold();
        op32(32'h0000_0100, 1'b1);
        cmp++;
        if (ndone !== 1 || lat !== 5) begin
            err++;
            $display("FAIL hold_done: dones=%0d lat=%0d want 1/5", ndone, lat);
        end
`ifdef FLAG_MSB_IDX_EN
        cmp++;
        if (r_msb !== 5'd8) begin
            err++;
            $display("FAIL hold_msb: got %0d want 8", r_msb);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        bit second;
        d1 = 0;
        d2 = 0;
        second = 1'b0;
        @(negedge clk);
        start = 1'b1;
        din = 32'h0000_0080;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done && d1 == 0) begin
                d1 = i;
`ifdef FLAG_MSB_IDX_EN
                cmp++;
                if (msb_idx !== 5'd7) begin
                    err++;
                    $display("FAIL b2b_msb1: got %0d want 7", msb_idx);
                end
`endif
                start = 1'b1;
                din = 32'h4000_0000;
                second = 1'b1;
            end else if (done && second) begin
                d2 = i;
                second = 1'b0;
`ifdef FLAG_MSB_IDX_EN
                cmp++;
                if (msb_idx !== 5'd30) begin
                    err++;
                    $display("FAIL b2b_msb2: got %0d want 30", msb_idx);
                end
`endif
            end
        end
        cmp++;
        if (d1 !== 5 || d2 !== 10) begin
            err++;
            $display("FAIL b2b_timing: done at %0d,%0d want 5,10", d1, d2);
        end
    endtask

    task automatic test_reset_mid();
        int nd;
        nd = 0;
        @(negedge clk);
        start = 1'b1;
        din = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        cmp++;
        if (nd !== 0) begin
            err++;
            $display("FAIL rstmid_done: got %0d dones want 0", nd);
        end
        cmp++;
        if ({busy, done, any_set, zero} !== 4'b0000) begin
            err++;
            $display("FAIL rstmid_flags: got %b want 0000",
                     {busy, done, any_set, zero});
        end
`ifdef FLAG_MSB_IDX_EN
        cmp++;
        if (msb_idx !== 5'd0) begin
            err++;
            $display("FAIL rstmid_msb: got %0d want 0", msb_idx);
        end
`endif
        op32(32'h0, 1'b0);
        cmp++;
        if (lat !== 5 || r_zero !== 1'b1 || r_any !== 1'b0) begin
            err++;
            $display("FAIL rstmid_next: lat=%0d zero=%b any=%b want 5/1/0",
                     lat, r_zero, r_any);
        end
    endtask

    task automatic test_param16(input logic [15:0] d, input logic e_any,
                                input int e_msb);
        int l16;
        l16 = 0;
        @(negedge clk);
        start16 = 1'b1;
        din16 = d;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start16 = 1'b0;
            if (done16 && l16 == 0) begin
                l16 = i;
                cmp++;
                if (any16 !== e_any || zero16 !== ~e_any) begin
                    err++;
                    $display("FAIL p16_flags: any=%b zero=%b want any=%b",
                             any16, zero16, e_any);
                end
`ifdef FLAG_MSB_IDX_EN
                cmp++;
                if (int'(msb16) !== e_msb) begin
                    err++;
                    $display("FAIL p16_msb: got %0d want %0d", msb16, e_msb);
                end
`endif
            end
        end
        cmp++;
        if (l16 !== 5) begin
            err++;
            $display("FAIL p16_lat: got %0d want 5 (d=%h msb=%0d)",
                     l16, d, e_msb);
        end
    endtask

    initial begin
        test_reset();
        test_vec("zero", 32'h0000_0000, 1'b0, 0);
        test_vec("msb31", 32'h8000_0000, 1'b1, 31);
        test_vec("lsb", 32'h0000_0001, 1'b1, 0);
        test_vec("mid", 32'h0001_0F00, 1'b1, 16);
        test_vec("lowchunk", 32'h0000_0030, 1'b1, 5);
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_param16(16'h0040, 1'b1, 6);
        test_param16(16'h0000, 1'b0, 0);
        test_param16(16'h8001, 1'b1, 15);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule

// File: doc/flag_reduce_seq.md
# flag_reduce_seq

Parametrised, multi-cycle successor to the calculator's 32-bit OR-reduce zero detector. It captures a WIDTH-bit result word, scans it MSB-first in CHUNK-bit slices over WIDTH/CHUNK cycles, and reports any-bit-set and zero flags. It can optionally report the index of the most significant set bit. It sits after the calculator datapath result register and feeds the status and normalisation logic through a start/busy/done handshake.

## Interface
- WIDTH, 32, operand width; multiple of CHUNK, at least 2.
- CHUNK, 8, bits reduced per cycle; divides WIDTH.
- IDXW, $clog2(WIDTH), width of msb_idx (derived localparam, not overridable).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- data_in  in  WIDTH  operand; captured on the accepting edge.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- any_set  out  1  OR of all captured bits.
- zero  out  1  ~any_set, qualified by a completed scan.
- msb_idx  out  IDXW  index of the highest set bit (FLAG_MSB_IDX_EN only).

## Operation
- The FSM has three states: IDLE, SCAN, DONE. Let NCH = WIDTH/CHUNK.
- IDLE: when start=1, load data_in into the shift register, clear acc and found, set cnt=0, and go to SCAN.
- SCAN: each cycle, OR the top CHUNK bits of the shift register into acc, then shift left by CHUNK.
- SCAN, with FLAG_MSB_IDX_EN: on the first cycle whose slice is nonzero (found=0), latch idx = WIDTH-1 - cnt*CHUNK - lz, where lz is the number of leading zeros in the slice, and set found=1.
- SCAN: increment cnt; after the slice at cnt=NCH-1, go to DONE.
- DONE: drive any_set=acc, zero=~acc, msb_idx=idx (0 if acc=0), and pulse done.
  - If start=1 in DONE, capture data_in and go to SCAN (back-to-back operation).
  - Otherwise go to IDLE.
- Result outputs are registered and hold their values until the next DONE.
- start is ignored while busy=1. data_in is don't-care except on the accepting edge.
- Latency is fixed; there is no early exit on the first nonzero slice.
- rst in any state returns the FSM to IDLE and clears the shift register, cnt, acc, found, and idx.
  - Any in-flight scan is discarded and produces no done.

## Timing
- Reset values: busy=0, done=0, any_set=0, zero=0, msb_idx=0.
- zero=0 after reset means no result is available yet; zero is not a claim that the operand is nonzero.
- If start is accepted at edge k:
  - busy=1 in cycles k+1 through k+NCH.
  - done=1, with updated outputs, in cycle k+NCH+1; busy=0 in that cycle.
  - Default configuration (NCH=4): done appears 5 cycles after start.
- Throughput: one operand per NCH+1 cycles.
- start during the DONE cycle is accepted, and the next done follows NCH+1 cycles later.

## Configuration
- FLAG_MSB_IDX_EN defined: the msb_idx port exists, along with the idx/found registers and the per-slice leading-one detector.
- FLAG_MSB_IDX_EN undefined: the msb_idx port and its logic are absent.
  - Flags, latency, and handshake are identical in both configurations.

## Structure
- Package flag_reduce_pkg holds:
  - the state enum typedef (IDLE, SCAN, DONE);
  - the default WIDTH/CHUNK localparams;
  - a function for the NCH/IDXW derivation.
- Submodule chunk_lzd: combinational leading-zero count of a CHUNK-bit slice plus a slice-nonzero output. It is instantiated only under FLAG_MSB_IDX_EN.
- The top level contains the FSM, shift register, counter, accumulator, and output registers.

## Test plan
- Zero operand: data_in=32'h0000_0000 with a start pulse -> done 5 cycles later, zero=1, any_set=0, msb_idx=0.
- MSB set: data_in=32'h8000_0000 -> any_set=1, zero=0, msb_idx=31.
- LSB and middle bits:
  - data_in=32'h0000_0001 -> msb_idx=0.
  - data_in=32'h0001_0F00 -> msb_idx=16; later set bits do not overwrite it.
- Handshake:
  - start held high for the whole scan with data changing -> exactly one done, with the result of the first-captured word.
  - Back-to-back start in the DONE cycle -> a second done exactly 5 cycles later.
- Reset mid-operation: rst asserted at cycle 2 of a scan of 32'hFFFF_FFFF -> no done; all outputs at reset values; the next start of 32'h0 gives zero=1.
- Non-default parameters: WIDTH=16, CHUNK=4, data_in=16'h0040 -> done 5 cycles after start, msb_idx=6; also with FLAG_MSB_IDX_EN undefined, confirm the flags match.
